// File: rtl/pfd_pkg.sv
// rtl/pfd_pkg.sv - shared state type and sizing helpers for the sampled phase-frequency detector
package pfd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DN   = 2'd2,
      BOTH = 2'd3
   } pfd_state_e;

   // Signed error width: magnitude up to max_pulse plus a sign bit.
   function automatic int err_width(input int max_pulse);
      return $clog2(max_pulse + 1) + 1;
   endfunction

   // Width of the lock counter, which saturates at lock_count.
   function automatic int lock_cnt_width(input int lock_count);
      return $clog2(lock_count + 1);
   endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - synchronizer chain with registered rising-edge detect
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic d_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;

   // Sync flops, previous-value register and the gated, registered rise pulse
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= en_i & sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/pfd_sampled.sv
// rtl/pfd_sampled.sv - sampled digital PFD with up/down drive, signed phase error and lock flag
module pfd_sampled
   import pfd_pkg::*;
#(
   parameter  int SYNC_STAGES = 2,
   parameter  int MIN_PULSE   = 2,
   parameter  int MAX_PULSE   = 255,
   parameter  int LOCK_WINDOW = 1,
   parameter  int LOCK_COUNT  = 16,
   localparam int ERR_W       = err_width(MAX_PULSE)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ref_in,
   input  logic                    fb_in,
   output logic                    up,
   output logic                    down,
   output logic signed [ERR_W-1:0] phase_err,
   output logic                    err_valid,
   output logic                    lock
);

   localparam int CNT_W   = $clog2(MAX_PULSE + 1);
   localparam int LK_W    = lock_cnt_width(LOCK_COUNT);
   localparam int BLANK_W = $clog2(SYNC_STAGES + 2);
   localparam int BOTH_W  = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;

   localparam logic [CNT_W-1:0]          CNT_MAX    = CNT_W'(MAX_PULSE);
   localparam logic [LK_W-1:0]           LK_MAX     = LK_W'(LOCK_COUNT);
   localparam logic [BLANK_W-1:0]        BLANK_INIT = BLANK_W'(SYNC_STAGES + 1);
   localparam logic [BOTH_W-1:0]         BOTH_LAST  = BOTH_W'(MIN_PULSE - 1);
   localparam logic signed [ERR_W-1:0]   WIN_POS    = ERR_W'(LOCK_WINDOW);
   localparam logic signed [ERR_W-1:0]   WIN_NEG    = ERR_W'(-LOCK_WINDOW);

   logic ref_rise, fb_rise, rise_en;

   pfd_state_e              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [BOTH_W-1:0]       both_q, both_d;
   logic                    pend_ref_q, pend_ref_d, pend_fb_q, pend_fb_d;
   logic signed [ERR_W-1:0] err_q, err_d;
   logic                    err_valid_q, err_valid_d;
   logic                    up_q, down_q;
   logic [BLANK_W-1:0]      blank_q, blank_d;
   logic [LK_W-1:0]         lk_cnt_q, lk_cnt_d;
   logic                    lock_q;

   logic signed [ERR_W-1:0] lead;
   logic                    launch, start_ref, start_fb, in_win;

   // Rises are suppressed until the blanking counter drains after reset.
   assign rise_en = (blank_q == '0);

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
      .clk_i (clk),
      .rst_i (rst),
      .en_i  (rise_en),
      .d_i   (ref_in),
      .rise_o(ref_rise)
   );

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
      .clk_i (clk),
      .rst_i (rst),
      .en_i  (rise_en),
      .d_i   (fb_in),
      .rise_o(fb_rise)
   );

   assign lead = $signed({1'b0, cnt_q});

   // Next-state logic: lead counting in UP/DN, pending capture in BOTH, IDLE rules on launch
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      both_d      = both_q;
      pend_ref_d  = pend_ref_q;
      pend_fb_d   = pend_fb_q;
      err_d       = err_q;
      err_valid_d = 1'b0;
      start_ref   = ref_rise;
      start_fb    = fb_rise;
      launch      = (state_q == IDLE);

      case (state_q)
         UP: begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            if (fb_rise) begin
               state_d     = BOTH;
               both_d      = BOTH_LAST;
               err_d       = lead;
               err_valid_d = 1'b1;
            end
         end
         DN: begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            if (ref_rise) begin
               state_d     = BOTH;
               both_d      = BOTH_LAST;
               err_d       = -lead;
               err_valid_d = 1'b1;
            end
         end
         BOTH: begin
            // Repeat rises on one input merge into a single pending flag.
            start_ref  = pend_ref_q | ref_rise;
            start_fb   = pend_fb_q | fb_rise;
            pend_ref_d = start_ref;
            pend_fb_d  = start_fb;
            if (both_q == '0) begin
               launch = 1'b1;
            end else begin
               both_d = both_q - BOTH_W'(1);
            end
         end
         default: ;
      endcase

      if (launch) begin
         pend_ref_d = 1'b0;
         pend_fb_d  = 1'b0;
         if (start_ref && start_fb) begin
            state_d     = BOTH;
            both_d      = BOTH_LAST;
            err_d       = '0;
            err_valid_d = 1'b1;
         end else if (start_ref) begin
            state_d = UP;
            cnt_d   = CNT_W'(1);
         end else if (start_fb) begin
            state_d = DN;
            cnt_d   = CNT_W'(1);
         end else begin
            state_d = IDLE;
         end
      end
   end

   // Lock counter and blanking counter next values
   always_comb begin
      in_win   = (err_q <= WIN_POS) && (err_q >= WIN_NEG);
      lk_cnt_d = lk_cnt_q;
      if (err_valid_q) begin
         if (!in_win) begin
            lk_cnt_d = '0;
         end else if (lk_cnt_q != LK_MAX) begin
            lk_cnt_d = lk_cnt_q + LK_W'(1);
         end
      end
      blank_d = (blank_q != '0) ? blank_q - BLANK_W'(1) : blank_q;
   end

   // FSM state, lead counter, pending flags and registered up/down/error outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         both_q      <= '0;
         pend_ref_q  <= 1'b0;
         pend_fb_q   <= 1'b0;
         err_q       <= '0;
         err_valid_q <= 1'b0;
         up_q        <= 1'b0;
         down_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         both_q      <= both_d;
         pend_ref_q  <= pend_ref_d;
         pend_fb_q   <= pend_fb_d;
         err_q       <= err_d;
         err_valid_q <= err_valid_d;
         up_q        <= (state_d == UP) || (state_d == BOTH);
         down_q      <= (state_d == DN) || (state_d == BOTH);
      end
   end

   // Post-reset blanking and lock detection
   always_ff @(posedge clk) begin
      if (rst) begin
         blank_q  <= BLANK_INIT;
         lk_cnt_q <= '0;
         lock_q   <= 1'b0;
      end else begin
         blank_q  <= blank_d;
         lk_cnt_q <= lk_cnt_d;
         lock_q   <= (lk_cnt_d == LK_MAX);
      end
   end

   assign up        = up_q;
   assign down      = down_q;
   assign phase_err = err_q;
   assign err_valid = err_valid_q;
   assign lock      = lock_q;

endmodule

// File: tb/tb_pfd_sampled.sv
// tb/tb_pfd_sampled.sv - scoreboard bench for pfd_sampled with directed edge patterns
module tb_pfd_sampled;

   logic              clk = 1'b0;
   logic              rst, ref_in, fb_in;
   logic              up, down, err_valid, lock;
   logic signed [8:0] phase_err;

   int tests = 0;
   int fails = 0;
   int exp_q[$];

   bit ref_pat[512];
   bit fb_pat[512];
   bit rst_pat[512];
   bit up_s[513];
   bit dn_s[513];
   bit lk_s[513];

   pfd_sampled dut (
      .clk      (clk),
      .rst      (rst),
      .ref_in   (ref_in),
      .fb_in    (fb_in),
      .up       (up),
      .down     (down),
      .phase_err(phase_err),
      .err_valid(err_valid),
      .lock     (lock)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_pat();
      for (int i = 0; i < 512; i++) begin
         ref_pat[i] = 1'b0;
         fb_pat[i]  = 1'b0;
         rst_pat[i] = 1'b0;
      end
   endtask

   // Drive one pattern step per negedge; sample index m = step + 1.
   task automatic run(input int n);
      for (int t = 0; t < n; t++) begin
         ref_in = ref_pat[t];
         fb_in  = fb_pat[t];
         rst    = rst_pat[t];
         @(negedge clk);
         up_s[t+1] = up;
         dn_s[t+1] = down;
         lk_s[t+1] = lock;
      end
   endtask

   // which: 0 = up, 1 = down, 2 = down without up
   function automatic int count_hi(input int which, input int lo, input int hi);
      int c = 0;
      for (int m = lo; m <= hi; m++) begin
         if (which == 0 && up_s[m]) c++;
         if (which == 1 && dn_s[m]) c++;
         if (which == 2 && dn_s[m] && !up_s[m]) c++;
      end
      return c;
   endfunction

   // Scoreboard monitor: every strobe must match the oldest expected error
   always @(negedge clk) begin
      int e;
      if (err_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got phase_err=%0d, expected no strobe", phase_err);
         end else begin
            e = exp_q.pop_front();
            chk("phase_err", int'(phase_err), e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst    = 1'b1;
      ref_in = 1'b0;
      fb_in  = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_up", up, 0);
      chk("rst_down", down, 0);
      chk("rst_err_valid", err_valid, 0);
      chk("rst_phase_err", int'(phase_err), 0);
      chk("rst_lock", lock, 0);
      clear_pat();
      run(10);

      // Ref leads fb by 5 cycles
      clear_pat();
      for (int t = 0; t < 10; t++) ref_pat[t] = 1'b1;
      for (int t = 5; t < 15; t++) fb_pat[t] = 1'b1;
      exp_q.push_back(5);
      run(30);
      chk("a_up_before", up_s[3], 0);
      chk("a_up_start", up_s[4], 1);
      chk("a_up_count", count_hi(0, 1, 30), 7);
      chk("a_dn_before_both", dn_s[8], 0);
      chk("a_dn_both", dn_s[9], 1);
      chk("a_dn_count", count_hi(1, 1, 30), 2);
      chk("a_up_after", up_s[11], 0);
      chk("a_lock", lk_s[30], 0);

      // Coincident edges until lock
      for (int p = 0; p < 16; p++) begin
         clear_pat();
         for (int t = 0; t < 8; t++) begin
            ref_pat[t] = 1'b1;
            fb_pat[t]  = 1'b1;
         end
         exp_q.push_back(0);
         run(20);
         if (p == 0) begin
            chk("b_up_count", count_hi(0, 1, 20), 2);
            chk("b_dn_count", count_hi(1, 1, 20), 2);
         end
         if (p == 14) chk("b_lock_at_15", lock, 0);
         if (p == 15) begin
            chk("b_lock_strobe_cycle", lk_s[4], 0);
            chk("b_lock_rise", lk_s[5], 1);
         end
      end

      // Injected 3-cycle offset drops lock the cycle after its strobe
      clear_pat();
      for (int t = 0; t < 8; t++) ref_pat[t] = 1'b1;
      for (int t = 3; t < 11; t++) fb_pat[t] = 1'b1;
      exp_q.push_back(3);
      run(20);
      chk("b_lock_held", lk_s[7], 1);
      chk("b_lock_drop", lk_s[8], 0);

      // Fb leads for 400 cycles: lead counter saturates
      clear_pat();
      for (int t = 0; t < 410; t++) fb_pat[t] = 1'b1;
      for (int t = 400; t < 410; t++) ref_pat[t] = 1'b1;
      exp_q.push_back(-255);
      run(420);
      chk("c_dn_start", dn_s[4], 1);
      chk("c_up_start", up_s[4], 0);
      chk("c_dn_hold", dn_s[300], 1);
      chk("c_dn_last", dn_s[403], 1);
      chk("c_both", up_s[404] & dn_s[404], 1);
      chk("c_dn_count", count_hi(1, 1, 420), 402);
      chk("c_up_count", count_hi(0, 1, 420), 2);

      // Ref at twice the fb frequency
      clear_pat();
      for (int t = 0; t < 90; t++) begin
         ref_pat[t] = ((t % 10) < 5);
         fb_pat[t]  = (((t + 17) % 20) < 10);
      end
      exp_q.push_back(3);
      for (int i = 0; i < 4; i++) exp_q.push_back(13);
      run(110);
      chk("d_down_alone", count_hi(2, 1, 110), 0);

      // Ref rise one cycle into BOTH
      clear_pat();
      ref_pat[0] = 1'b1;
      ref_pat[1] = 1'b1;
      for (int t = 5; t < 20; t++) ref_pat[t] = 1'b1;
      for (int t = 4; t < 8; t++) fb_pat[t] = 1'b1;
      for (int t = 12; t < 20; t++) fb_pat[t] = 1'b1;
      exp_q.push_back(4);
      exp_q.push_back(6);
      run(30);
      chk("e_both", up_s[8] & dn_s[8], 1);
      chk("e_both_hold", dn_s[9], 1);
      chk("e_up_direct", up_s[10], 1);
      chk("e_dn_released", dn_s[10], 0);

      // Reset mid-UP with ref held high
      clear_pat();
      for (int t = 0; t < 40; t++) ref_pat[t] = 1'b1;
      rst_pat[6] = 1'b1;
      run(50);
      chk("f_up_before_rst", up_s[6], 1);
      chk("f_up_after_rst", up_s[7], 0);
      chk("f_no_false_up", count_hi(0, 7, 50), 0);
      chk("f_no_down", count_hi(1, 7, 50), 0);

      clear_pat();
      run(10);
      chk("strobes_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pfd_sampled.md
# pfd_sampled

Sampled digital phase-frequency detector for the CDR loop. Oversamples the asynchronous reference and feedback clocks on the system clock and detects their rising edges. Drives the `up`/`down` control pair consumed by the charge pump, and reports a signed per-comparison phase error plus a lock flag.

## Interface

Parameters:
- `SYNC_STAGES`, 2: synchronizer depth per input (min 2).
- `MIN_PULSE`, 2: anti-dead-zone width; cycles with `up` and `down` both high after each comparison (min 1).
- `MAX_PULSE`, 255: saturation limit of the lead counter.
- `LOCK_WINDOW`, 1: max |phase_err| counted as in-lock.
- `LOCK_COUNT`, 16: consecutive in-window comparisons required for `lock`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system sample clock.
- `rst` in 1: synchronous active-high reset.
- `ref_in` in 1: reference clock, asynchronous to `clk`.
- `fb_in` in 1: divided VCO feedback, asynchronous to `clk`.
- `up` out 1: charge-pump source enable; registered.
- `down` out 1: charge-pump sink enable; registered.
- `phase_err` out ERR_W: signed, in `clk` cycles; positive means ref leads. ERR_W = $clog2(MAX_PULSE+1)+1.
- `err_valid` out 1: one-cycle strobe qualifying `phase_err`.
- `lock` out 1: loop-locked flag.

## Operation

- Each input passes through a `SYNC_STAGES` flop chain, then a previous-value register. A rising edge (`rise`) is synced=1 and prev=0.
- After reset release, `rise` is masked for SYNC_STAGES+1 cycles (blanking counter). This stops an input held high through reset from producing a false edge.
- FSM states: IDLE, UP, DN, BOTH. The lead counter `cnt` is saturating at MAX_PULSE.
- **IDLE** (up=0, down=0):
  - ref rise only → UP, cnt=1.
  - fb rise only → DN, cnt=1.
  - both rise in the same cycle → BOTH; emit err=0.
- **UP** (up=1):
  - Each cycle cnt=min(cnt+1, MAX_PULSE).
  - A further ref rise is ignored (frequency-detect behaviour; up stays high).
  - fb rise → BOTH; emit err=+cnt.
- **DN** (down=1): symmetric to UP. ref rise → BOTH; emit err=−cnt.
- **BOTH** (up=1, down=1):
  - Lasts exactly MIN_PULSE cycles, then exits.
  - Rises arriving during BOTH set one pending flag per input. Repeat rises on the same input are merged.
  - On exit, pending flags are evaluated as the IDLE rules and the flags are cleared. With no pending flags, the next state is IDLE.
- Emit means: `phase_err` is loaded and `err_valid`=1 for one cycle, registered together with the transition into BOTH.
- Lock detector, on each `err_valid`:
  - If |phase_err| ≤ LOCK_WINDOW, `lk_cnt` increments, saturating at LOCK_COUNT.
  - Otherwise `lk_cnt`=0.
  - `lock` = (lk_cnt == LOCK_COUNT), registered.
  - `lock` falls on the cycle after an out-of-window error strobe.
- Saturation: at cnt=MAX_PULSE the state is held (up or down stays high) and the emitted magnitude is MAX_PULSE. No wrap.

## Timing

- Reset values: up=0, down=0, phase_err=0, err_valid=0, lock=0. Also state=IDLE, cnt=0, lk_cnt=0, pending flags=0, sync chain=0, blanking counter loaded.
- Reset asserted mid-operation takes effect at the next `clk` edge. Any in-flight UP/DN/BOTH pulse is aborted with no err strobe.
- Latency: an input first sampled high at edge k gives `rise` at edge k+SYNC_STAGES. `up`/`down` change at edge k+SYNC_STAGES+1.
- The err strobe lands on the same edge that `up` and `down` both go high.
- In steady lock, `lock` follows the LOCK_COUNT-th in-window strobe by 1 cycle.
- Inputs must hold each level ≥ 2 `clk` periods. Shorter pulses may be missed and are not an error.

## Structure

- Package `pfd_pkg` holds:
  - the `pfd_state_e` enum {IDLE, UP, DN, BOTH};
  - an `err_width(max_pulse)` constant function;
  - `LOCK_CNT_W` sizing.
- Sub-module `edge_sync` (synchronizer + prev register + rise output; `SYNC_STAGES` parameter), instantiated once for `ref_in` and once for `fb_in`.
- Top-level contents: blanking counter, FSM, lead counter, pending flags, error register, lock detector.

## Test plan

- **Ref leads by 5 cycles:** ref rises, fb rises 5 cycles later → up high 5 cycles, then up=down=1 for 2 cycles; phase_err=+5, err_valid 1 cycle; lock stays 0.
- **Coincident edges:** same-cycle rises on both inputs → BOTH only; phase_err=0; after 16 periods lock=1, and lock=0 the cycle after an injected 3-cycle offset.
- **Fb leads, saturation:** fb rises, ref held low for 400 cycles → down held continuously; on ref rise phase_err=−255, no wrap.
- **Frequency error:** ref at 2× fb frequency → extra ref rises in UP ignored; down never asserts outside BOTH; strobes are positive only.
- **Edge during BOTH:** ref rise 1 cycle into BOTH → pending honoured; FSM enters UP directly on BOTH exit with cnt=1.
- **Reset:** rst pulsed mid-UP with ref_in held high → up=0 the next cycle; no err strobe; no false UP after release.
